// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with configurable width/depth,
// registered count-derived flags, read-valid strobe, sticky error flags
// and synchronous flush.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int AFULL_TH  = (1 << ADDR_W) - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              clr_err,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   AFULL_C  = AFULL_TH[ADDR_W:0];
    localparam logic [ADDR_W:0]   AEMPTY_C = AEMPTY_TH[ADDR_W:0];
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              aempty_q, aempty_d;
    logic              afull_q, afull_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              rd_ok, wr_ok, mem_we;

    // Accept decisions, next pointers/count, and flags derived from next count
    always_comb begin
        rd_ok        = rd_en && !empty_q;
        // A full FIFO still takes a write when a read frees a slot this edge
        wr_ok        = wr_en && (!full_q || rd_ok);
        mem_we       = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        ovf_d        = ovf_q && !clr_err;
        unf_d        = unf_q && !clr_err;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_ok) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_ok) begin
                dout_d       = mem[rd_ptr_q];
                dout_valid_d = 1'b1;
                rd_ptr_d     = rd_ptr_q + PTR_ONE;
            end
            if (wr_ok && !rd_ok)
                count_d = count_q + CNT_ONE;
            else if (rd_ok && !wr_ok)
                count_d = count_q - CNT_ONE;
            // A new error in the clear cycle wins over clr_err
            if (wr_en && !wr_ok) ovf_d = 1'b1;
            if (rd_en && !rd_ok) unf_d = 1'b1;
        end

        empty_d  = (count_d == '0);
        full_d   = (count_d == DEPTH_C);
        aempty_d = (count_d <= AEMPTY_C);
        afull_d  = (count_d >= AFULL_C);
    end

    // Storage array; not reset, contents are only meaningful behind count
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q] <= din;
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            aempty_q     <= 1'b1;
            afull_q      <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            aempty_q     <= aempty_d;
            afull_q      <= afull_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    assign dout         = dout_q;
    assign dout_valid   = dout_valid_q;
    assign count        = count_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = aempty_q;
    assign almost_full  = afull_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param: directed vector table, corner-case
// sequences and a randomized run against a queue reference model.
module tb_sync_fifo_param;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush, clr_err, wr_en, rd_en;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic [AW:0]   count;
    logic          empty, full, almost_empty, almost_full, overflow, underflow;

    sync_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AFULL_TH(14), .AEMPTY_TH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err),
        .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .dout_valid(dout_valid), .count(count),
        .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout;
    logic          m_dv, m_ov, m_un;

    typedef struct {
        logic        f, c, w, r;
        logic [7:0]  d;
        logic [7:0]  e_dout;
        logic        e_dv;
        logic [4:0]  e_cnt;
        logic [5:0]  e_fl;   // {empty, full, aempty, afull, overflow, underflow}
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(input logic f, input logic c, input logic w, input logic r,
                                input logic [7:0] d, input logic [7:0] ed, input logic edv,
                                input logic [4:0] ec, input logic [5:0] efl);
        vec_t v;
        v.f = f; v.c = c; v.w = w; v.r = r; v.d = d;
        v.e_dout = ed; v.e_dv = edv; v.e_cnt = ec; v.e_fl = efl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle; the model advances on the same edge as the DUT
    task automatic step(input logic f, input logic c, input logic w, input logic r,
                        input logic [7:0] d);
        logic rok, wok;
        flush = f; clr_err = c; wr_en = w; rd_en = r; din = d;
        @(posedge clk);
        if (f) begin
            mq.delete();
            m_dv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
        end else begin
            rok = r && (mq.size() > 0);
            wok = w && ((mq.size() < DEPTH) || rok);
            m_dv = rok;
            if (rok) m_dout = mq.pop_front();
            if (wok) mq.push_back(d);
            m_ov = (m_ov && !c) || (w && !wok);
            m_un = (m_un && !c) || (r && !rok);
        end
        #1;
        flush = 1'b0; clr_err = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic check_model(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= 2));
        chk({tag, ".afull"}, 32'(almost_full), 32'(n >= 14));
        chk({tag, ".dv"}, 32'(dout_valid), 32'(m_dv));
        chk({tag, ".dout"}, 32'(dout), 32'(m_dout));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ov));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_un));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".dout"}, 32'(dout), 32'h0);
        chk({tag, ".dv"}, 32'(dout_valid), 32'h0);
        chk({tag, ".count"}, 32'(count), 32'h0);
        chk({tag, ".flags"},
            32'({empty, full, almost_empty, almost_full, overflow, underflow}),
            32'(6'b101000));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; clr_err = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        m_dout = '0; m_dv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
        #12;
        check_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table starting from empty
        tbl[0]  = mk(1'b0,1'b0,1'b1,1'b0,8'h11, 8'h00,1'b0,5'd1, 6'b001000);
        tbl[1]  = mk(1'b0,1'b0,1'b1,1'b0,8'h22, 8'h00,1'b0,5'd2, 6'b001000);
        tbl[2]  = mk(1'b0,1'b0,1'b1,1'b0,8'h33, 8'h00,1'b0,5'd3, 6'b000000);
        tbl[3]  = mk(1'b0,1'b0,1'b0,1'b1,8'h00, 8'h11,1'b1,5'd2, 6'b001000);
        tbl[4]  = mk(1'b0,1'b0,1'b1,1'b1,8'h44, 8'h22,1'b1,5'd2, 6'b001000);
        tbl[5]  = mk(1'b0,1'b0,1'b0,1'b0,8'h00, 8'h22,1'b0,5'd2, 6'b001000);
        tbl[6]  = mk(1'b0,1'b0,1'b0,1'b1,8'h00, 8'h33,1'b1,5'd1, 6'b001000);
        tbl[7]  = mk(1'b0,1'b0,1'b0,1'b1,8'h00, 8'h44,1'b1,5'd0, 6'b101000);
        tbl[8]  = mk(1'b0,1'b0,1'b0,1'b1,8'h00, 8'h44,1'b0,5'd0, 6'b101001);
        tbl[9]  = mk(1'b0,1'b1,1'b0,1'b0,8'h00, 8'h44,1'b0,5'd0, 6'b101000);
        tbl[10] = mk(1'b0,1'b0,1'b1,1'b1,8'h55, 8'h44,1'b0,5'd1, 6'b001001);
        tbl[11] = mk(1'b1,1'b0,1'b1,1'b0,8'h66, 8'h44,1'b0,5'd0, 6'b101000);
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].f, tbl[i].c, tbl[i].w, tbl[i].r, tbl[i].d);
            chk($sformatf("vec%0d.dout", i), 32'(dout), 32'(tbl[i].e_dout));
            chk($sformatf("vec%0d.dv", i), 32'(dout_valid), 32'(tbl[i].e_dv));
            chk($sformatf("vec%0d.count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d.flags", i),
                32'({empty, full, almost_empty, almost_full, overflow, underflow}),
                32'(tbl[i].e_fl));
        end

        // Fill / drain with threshold and error boundaries
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 8'(i));
            if (i == 12) chk("fill.afull13", 32'(almost_full), 32'h0);
            if (i == 13) chk("fill.afull14", 32'(almost_full), 32'h1);
            if (i == 14) chk("fill.full15", 32'(full), 32'h0);
        end
        chk("fill.full16", 32'(full), 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'hEE);
        chk("fill.ovf", 32'(overflow), 32'h1);
        chk("fill.cnt", 32'(count), 32'd16);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
            chk($sformatf("drain%0d.dout", i), 32'(dout), 32'(i));
            chk($sformatf("drain%0d.dv", i), 32'(dout_valid), 32'h1);
        end
        chk("drain.empty", 32'(empty), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("drain.unf", 32'(underflow), 32'h1);
        chk("drain.dv", 32'(dout_valid), 32'h0);
        check_model("drain");
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

        // Pointer wrap
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
        chk("wrap.cnt12", 32'(count), 32'd12);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
            chk($sformatf("wrap%0d.dout", i), 32'(dout), 32'(8'h60 + i));
        end
        chk("wrap.cnt0", 32'(count), 32'd0);

        // Simultaneous read/write while full
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'hA5);
        chk("sim.dout", 32'(dout), 32'h10);
        chk("sim.cnt", 32'(count), 32'd16);
        chk("sim.ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("sim.a5", 32'(dout), 32'hA5);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h77);
        chk("sim0.cnt", 32'(count), 32'd1);
        chk("sim0.unf", 32'(underflow), 32'h1);
        check_model("sim0");
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // Flush with overflow pending and a concurrent write
        for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("fl.pre.cnt", 32'(count), 32'd7);
        chk("fl.pre.ovf", 32'(overflow), 32'h1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h99);
        chk("fl.cnt", 32'(count), 32'd0);
        chk("fl.empty", 32'(empty), 32'h1);
        chk("fl.ovf", 32'(overflow), 32'h0);
        check_model("fl");
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'(i));
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        chk("clr.ovf_wins", 32'(overflow), 32'h1);

        // Asynchronous reset mid-operation
        #2 rst = 1'b1;
        #1 check_reset_vals("midrst");
        mq.delete(); m_dout = '0; m_dv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h3C);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("postrst.dout", 32'(dout), 32'h3C);
        check_model("postrst");

        // Randomized run against the queue model
        for (int i = 0; i < 4000; i++) begin
            int wp;
            logic f, c, w, r;
            wp = ((i / 300) % 2 == 0) ? 75 : 25;
            f = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 15) == 0);
            w = ($urandom_range(0, 99) < wp);
            r = ($urandom_range(0, 99) < (100 - wp));
            step(f, c, w, r, 8'($urandom));
            check_model($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
